// File: rtl/result_pipe.sv
// Back half of the RV32I pipeline: EX/MEM and MEM/WB registers, data-memory
// port, register-bank write port, forwarding sources and load-use stall.
module result_pipe #(
  parameter int unsigned XLEN           = 32,
  parameter bit          LOAD_USE_STALL = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            ex_valid,
  input  logic [4:0]      ex_rd,
  input  logic            ex_RegWrite,
  input  logic            ex_MemRead,
  input  logic            ex_MemWrite,
  input  logic [XLEN-1:0] ex_result,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  output logic            stall,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic            dmem_re,
  output logic            dmem_we,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [4:0]      EXMEMrd,
  output logic            EXMEM_RegWrite,
  output logic [XLEN-1:0] exmem_data,
  output logic [4:0]      MEMWBrd,
  output logic            MEMWB_RegWrite,
  output logic [XLEN-1:0] memwb_data
);

  logic            exmem_valid;
  logic [4:0]      exmem_rd;
  logic            exmem_RegWrite;
  logic            exmem_MemRead;
  logic            exmem_MemWrite;
  logic [XLEN-1:0] exmem_result;
  logic [XLEN-1:0] exmem_store_data;

  logic [4:0]      memwb_rd;
  logic            memwb_RegWrite;
  logic            memwb_is_load;
  logic [XLEN-1:0] memwb_result;

  logic            capture_valid;

  assign capture_valid = ex_valid & ~flush;

  // Read+write together is normalised to a write at capture, so the read
  // strobe and the load path both see it as a non-load.
  always_ff @(posedge clk) begin
    if (!reset) begin
      exmem_valid      <= 1'b0;
      exmem_rd         <= '0;
      exmem_RegWrite   <= 1'b0;
      exmem_MemRead    <= 1'b0;
      exmem_MemWrite   <= 1'b0;
      exmem_result     <= '0;
      exmem_store_data <= '0;
    end else if (capture_valid) begin
      exmem_valid      <= 1'b1;
      exmem_rd         <= ex_rd;
      exmem_RegWrite   <= ex_RegWrite & (ex_rd != 5'd0);
      exmem_MemRead    <= ex_MemRead & ~ex_MemWrite;
      exmem_MemWrite   <= ex_MemWrite;
      exmem_result     <= ex_result;
      exmem_store_data <= ex_store_data;
    end else begin
      exmem_valid      <= 1'b0;
      exmem_rd         <= '0;
      exmem_RegWrite   <= 1'b0;
      exmem_MemRead    <= 1'b0;
      exmem_MemWrite   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      memwb_rd       <= '0;
      memwb_RegWrite <= 1'b0;
      memwb_is_load  <= 1'b0;
      memwb_result   <= '0;
    end else begin
      memwb_rd       <= exmem_rd;
      memwb_RegWrite <= exmem_RegWrite;
      memwb_is_load  <= exmem_MemRead;
      memwb_result   <= exmem_result;
    end
  end

  assign dmem_addr  = exmem_result;
  assign dmem_wdata = exmem_store_data;
  assign dmem_re    = exmem_valid & exmem_MemRead;
  assign dmem_we    = exmem_valid & exmem_MemWrite;

  // A load's EX/MEM value is only an address, never a forwardable result.
  assign EXMEMrd        = exmem_rd;
  assign EXMEM_RegWrite = exmem_RegWrite & ~exmem_MemRead;
  assign exmem_data     = exmem_result;

  assign MEMWBrd        = memwb_rd;
  assign MEMWB_RegWrite = memwb_RegWrite;
  assign memwb_data     = memwb_is_load ? dmem_rdata : memwb_result;

  assign stall = LOAD_USE_STALL & ex_valid & ex_MemRead & (ex_rd != 5'd0) &
                 ((ex_rd == id_rs1) | (ex_rd == id_rs2));

endmodule

// File: doc/result_pipe.md
# result_pipe

Back half of the RV32I pipeline: EX/MEM and MEM/WB pipeline registers, data-memory port and register-bank write port. It produces the `EXMEMrd`/`MEMWBrd`/`*_RegWrite` and forwarding data that the forward unit and EX-stage operand muxes consume. It also raises the load-use stall that forwarding cannot cover. It sits between the ALU output and the register bank write port (rd, RegWrite, C).

## Interface
Parameters:
- `XLEN`, default 32. Datapath width.
- `LOAD_USE_STALL`, default 1. When 0, `stall` is tied low (used when memory is assumed combinational in unit tests).

Ports:
- `clk`  in  1. Single clock; all state updates on the rising edge.
- `reset`  in  1. Reset is synchronous and active-low (sampled on the `clk` rising edge; 0 = reset).
- `flush`  in  1. Kill the instruction entering EX/MEM this cycle.
- `ex_valid`  in  1. EX stage holds a real instruction.
- `ex_rd`  in  5. EX destination register.
- `ex_RegWrite`, `ex_MemRead`, `ex_MemWrite`  in  1 each. EX control bits.
- `ex_result`  in  XLEN. ALU result or memory address.
- `ex_store_data`  in  XLEN. Forwarded rs2 value for stores.
- `id_rs1`, `id_rs2`  in  5 each. Source registers of the instruction in ID.
- `stall`  out  1. Load-use hazard: hold IF/ID and PC, insert bubble into ID/EX.
- `dmem_addr`, `dmem_wdata`  out  XLEN. Data-memory address and write data.
- `dmem_re`, `dmem_we`  out  1 each. Data-memory read and write strobes.
- `dmem_rdata`  in  XLEN. Read data, valid the cycle after `dmem_re`.
- `EXMEMrd`  out  5; `EXMEM_RegWrite`  out  1; `exmem_data`  out  XLEN. Forward source, EX/MEM stage.
- `MEMWBrd`  out  5; `MEMWB_RegWrite`  out  1; `memwb_data`  out  XLEN. Forward source for MEM/WB. These three also drive the register bank `rd`, `RegWrite` and `C` inputs.

## Operation
EX/MEM register captures every cycle. The captured valid bit is `ex_valid & ~flush`.
- When that valid bit is 0, the stage loads as a bubble: all control bits 0, `rd` 0, data held.
- `ex_RegWrite` with `ex_rd == 0` is captured as RegWrite = 0. Writes to x0 never leave this block.

Data-memory port is driven directly from the EX/MEM register:
- `dmem_addr = exmem_result`.
- `dmem_wdata = exmem_store_data`.
- `dmem_re = exmem_valid & exmem_MemRead`.
- `dmem_we = exmem_valid & exmem_MemWrite`.
- MemRead and MemWrite both set: treated as a write only, with `dmem_re` forced to 0.

`EXMEM_RegWrite = exmem_RegWrite & ~exmem_MemRead`. A load's EX/MEM value is an address and is never advertised for forwarding. `exmem_data = exmem_result`.

MEM/WB register captures every cycle from EX/MEM:
- Control bits and rd are copied; `is_load = exmem_MemRead`.
- `memwb_data` is a mux on `is_load`: when 1 it is `dmem_rdata`, otherwise the registered ALU result.
- The result is registered; `dmem_rdata` is only muxed combinationally, never registered in this block.

Load-use detection is combinational:
- `stall = LOAD_USE_STALL & ex_valid & ex_MemRead & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2))`.
- The stall lasts one cycle. Upstream inserts a bubble (`ex_valid` = 0) on the next cycle, which deasserts `stall`.
- The dependent instruction then reaches EX while the load is in MEM/WB and gets its data via the MEM/WB forward path.

`flush` and `stall` in the same cycle: `flush` wins. The EX instruction is killed, and `stall` is still reported. Upstream ignores `stall` when it flushes.

## Timing
- Reset (`reset` = 0 at a rising edge) clears both stages: all valid and control bits 0, `EXMEMrd`/`MEMWBrd` = 0, `exmem_data`/`memwb_data` = 0, `dmem_re`/`dmem_we` = 0.
- `stall` is combinational; `stall` = 0 while `ex_valid` = 0, including during reset.
- Reset mid-operation drops in-flight instructions, with no memory write after the reset edge.
- Latencies:
  - EX input to `EXMEMrd`/`dmem_*`: 1 cycle.
  - EX input to `MEMWB_RegWrite`/`memwb_data` (register write): 2 cycles.
  - Register bank writes at the 3rd edge.
- Load: `dmem_re` in cycle N+1, `dmem_rdata` sampled in cycle N+2, presented on `memwb_data` in cycle N+2.
- No handshake with memory; memory must accept every access in one cycle.

## Test plan
- **Reset.** Hold `reset` = 0 for 2 cycles with `ex_valid` = 1. Required: all outputs 0, no `dmem_we`. Release reset: the first instruction appears on EX/MEM one cycle later.
- **ALU op.** `ex_rd` = 5, RegWrite = 1, result 0x0000_00AA. Required: next cycle `EXMEMrd` = 5, `EXMEM_RegWrite` = 1, `exmem_data` = 0xAA. The cycle after: `MEMWBrd` = 5, `memwb_data` = 0xAA.
- **Load.** `ex_rd` = 7, MemRead = 1, address 0x100, memory returns 0xDEADBEEF. Required: `dmem_re` = 1 with `dmem_addr` = 0x100, `EXMEM_RegWrite` = 0. Next cycle `MEMWB_RegWrite` = 1 and `memwb_data` = 0xDEADBEEF.
- **Load-use.** Load into x7 in EX with `id_rs2` = 7: `stall` = 1. Next cycle bubble (`ex_valid` = 0): `stall` = 0. Same load with `id_rs1` = 0 and `id_rs2` = 3: `stall` = 0.
- **x0 and flush.** `ex_rd` = 0 with RegWrite = 1: `EXMEM_RegWrite` = 0 and `MEMWB_RegWrite` = 0. A store with `flush` = 1: `dmem_we` stays 0.
- **Store.** Address 0x200, store data 0x1234, MemWrite = 1. Required: `dmem_we` = 1, `dmem_wdata` = 0x1234, `MEMWB_RegWrite` = 0.
